// File: rtl/addsub_arbiter.sv
// Two-requester arbiter sharing one 32-bit add/subtract unit, with a tagged response channel.
// Optional signed-overflow output is enabled by defining ADDSUB_ARB_OVF_EN.

module addsub_unit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
`ifdef ADDSUB_ARB_OVF_EN
  output logic        ovf,
`endif
  output logic [31:0] sum
);
  logic [31:0] bx;

  always_comb begin
    bx  = b ^ {32{sub}};
    sum = a + bx + {31'b0, sub};
`ifdef ADDSUB_ARB_OVF_EN
    ovf = (a[31] == bx[31]) && (sum[31] != a[31]);
`endif
  end
endmodule

module addsub_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
`ifdef ADDSUB_ARB_OVF_EN
  output logic        rsp_ovf,
`endif
  output logic [31:0] rsp_sum
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic        sub_q, sub_d, id_q, id_d, rsp_id_q, rsp_id_d, last_id_q, last_id_d;
  logic [31:0] unit_sum;
  logic        grant_id, accept;
`ifdef ADDSUB_ARB_OVF_EN
  logic        ovf_q, ovf_d, unit_ovf;
`endif

  addsub_unit u_unit (
    .a   (a_q),
    .b   (b_q),
    .sub (sub_q),
`ifdef ADDSUB_ARB_OVF_EN
    .ovf (unit_ovf),
`endif
    .sum (unit_sum)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    id_d      = id_q;
    sum_d     = sum_q;
    rsp_id_d  = rsp_id_q;
    last_id_d = last_id_q;
`ifdef ADDSUB_ARB_OVF_EN
    ovf_d     = ovf_q;
`endif
    // A lone requester always wins; a tie goes to whoever did not win last (RR) or to requester 0.
    if (RR_EN) grant_id = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;
    else       grant_id = ~req0_valid;
    accept     = (state_q == S_IDLE) && (req0_valid || req1_valid);
    req0_ready = !rst && accept && !grant_id;
    req1_ready = !rst && accept && grant_id;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d       = grant_id ? req1_a : req0_a;
          b_d       = grant_id ? req1_b : req0_b;
          sub_d     = grant_id ? req1_sub : req0_sub;
          id_d      = grant_id;
          last_id_d = grant_id;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        sum_d    = unit_sum;
        rsp_id_d = id_q;
`ifdef ADDSUB_ARB_OVF_EN
        ovf_d    = unit_ovf;
`endif
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      id_q      <= 1'b0;
      sum_q     <= '0;
      rsp_id_q  <= 1'b0;
      last_id_q <= 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      id_q      <= id_d;
      sum_q     <= sum_d;
      rsp_id_q  <= rsp_id_d;
      last_id_q <= last_id_d;
`ifdef ADDSUB_ARB_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_sum   = sum_q;
  assign rsp_id    = rsp_id_q;
`ifdef ADDSUB_ARB_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: a round-robin instance and a fixed-priority instance share stimulus.
module tb_addsub_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, s0 = 1'b0, s1 = 1'b0, rsp_ready = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        r0_rdy, r1_rdy, rv, rid;
  logic        fp_r0_rdy, fp_r1_rdy, fp_rv, fp_rid;
  logic [31:0] rsum, fp_rsum;
`ifdef ADDSUB_ARB_OVF_EN
  logic        rovf, fp_rovf;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0_rdy), .req0_a(a0), .req0_b(b0), .req0_sub(s0),
    .req1_valid(v1), .req1_ready(r1_rdy), .req1_a(a1), .req1_b(b1), .req1_sub(s1),
    .rsp_valid(rv), .rsp_ready(rsp_ready), .rsp_id(rid),
`ifdef ADDSUB_ARB_OVF_EN
    .rsp_ovf(rovf),
`endif
    .rsp_sum(rsum)
  );

  addsub_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(fp_r0_rdy), .req0_a(a0), .req0_b(b0), .req0_sub(s0),
    .req1_valid(v1), .req1_ready(fp_r1_rdy), .req1_a(a1), .req1_b(b1), .req1_sub(s1),
    .rsp_valid(fp_rv), .rsp_ready(rsp_ready), .rsp_id(fp_rid),
`ifdef ADDSUB_ARB_OVF_EN
    .rsp_ovf(fp_rovf),
`endif
    .rsp_sum(fp_rsum)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one op from requester id, returns the response fields once rsp_valid rises.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                       output logic [31:0] sum, output logic rsp_id_o, output logic ovf,
                       output int lat, output logic timed_out);
    int n = 0;
    timed_out = 1'b0;
    if (id) begin v1 = 1'b1; a1 = a; b1 = b; s1 = sub; end
    else    begin v0 = 1'b1; a0 = a; b0 = b; s0 = sub; end
    #1;
    while (!(id ? r1_rdy : r0_rdy) && n < 20) begin step(); n++; end
    if (n >= 20) timed_out = 1'b1;
    step();
    v0 = 1'b0; v1 = 1'b0;
    lat = 1;
    while (!rv && lat < 20) begin step(); lat++; end
    if (!rv) timed_out = 1'b1;
    sum = rsum; rsp_id_o = rid;
`ifdef ADDSUB_ARB_OVF_EN
    ovf = rovf;
`else
    ovf = 1'b0;
`endif
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = 32'd2; b0 = 32'd2;
    step(); step();
    total++; if (r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin bad++;
      $display("FAIL reset_ready: got %b%b want 00", r0_rdy, r1_rdy); end
    total++; if (rv !== 1'b0 || rsum !== 32'h0 || rid !== 1'b0) begin bad++;
      $display("FAIL reset_rsp: valid=%b sum=%h id=%b want 0/0/0", rv, rsum, rid); end
    rst = 1'b0;
    #1;
    total++; if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin bad++;
      $display("FAIL reset_first_grant: got r0=%b r1=%b want r0=1 r1=0", r0_rdy, r1_rdy); end
    step();
    v0 = 1'b0; v1 = 1'b0;
    step(); step();
    total++; if (rv !== 1'b1 || rsum !== 32'd4 || rid !== 1'b0) begin bad++;
      $display("FAIL reset_first_op: valid=%b sum=%h id=%b want 1/4/0", rv, rsum, rid); end
    handshake();
  endtask

  task automatic test_add();
    logic [31:0] sum; logic id, ovf, to; int lat;
    issue(1'b0, 32'd5, 32'd3, 1'b0, sum, id, ovf, lat, to);
    total++; if (to !== 1'b0 || lat != 2) begin bad++;
      $display("FAIL add_latency: got %0d (timeout=%b) want 2", lat, to); end
    total++; if (sum !== 32'd8 || id !== 1'b0 || ovf !== 1'b0) begin bad++;
      $display("FAIL add_result: sum=%h id=%b ovf=%b want 00000008/0/0", sum, id, ovf); end
    handshake();
    total++; if (rv !== 1'b0) begin bad++;
      $display("FAIL add_release: rsp_valid=%b want 0", rv); end
  endtask

  task automatic test_sub_wrap();
    logic [31:0] sum; logic id, ovf, to; int lat;
    issue(1'b1, 32'h0000_0000, 32'h1, 1'b1, sum, id, ovf, lat, to);
    total++; if (to || sum !== 32'hFFFF_FFFF || id !== 1'b1 || ovf !== 1'b0) begin bad++;
      $display("FAIL sub_wrap: sum=%h id=%b ovf=%b want ffffffff/1/0", sum, id, ovf); end
    handshake();
    issue(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, sum, id, ovf, lat, to);
    total++; if (to || sum !== 32'h8000_0000 || id !== 1'b1) begin bad++;
      $display("FAIL add_ovf_sum: sum=%h id=%b want 80000000/1", sum, id); end
`ifdef ADDSUB_ARB_OVF_EN
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL add_ovf_flag: got %b want 1", ovf); end
`endif
    handshake();
    issue(1'b0, 32'h8000_0000, 32'h1, 1'b1, sum, id, ovf, lat, to);
    total++; if (to || sum !== 32'h7FFF_FFFF || id !== 1'b0) begin bad++;
      $display("FAIL sub_ovf_sum: sum=%h id=%b want 7fffffff/0", sum, id); end
`ifdef ADDSUB_ARB_OVF_EN
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sub_ovf_flag: got %b want 1", ovf); end
`endif
    handshake();
  endtask

  task automatic test_round_robin();
    int rr_cyc[$], fp_cyc[$];
    logic rr_id[$], fp_id[$];
    int sum_err = 0;
    rst = 1'b1; step(); rst = 1'b0;
    v0 = 1'b1; a0 = 32'd10; b0 = 32'd1; s0 = 1'b0;
    v1 = 1'b1; a1 = 32'd10; b1 = 32'd1; s1 = 1'b1;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (r0_rdy) begin rr_cyc.push_back(c); rr_id.push_back(1'b0); end
      if (r1_rdy) begin rr_cyc.push_back(c); rr_id.push_back(1'b1); end
      if (fp_r0_rdy) begin fp_cyc.push_back(c); fp_id.push_back(1'b0); end
      if (fp_r1_rdy) begin fp_cyc.push_back(c); fp_id.push_back(1'b1); end
      if (rv && rsum !== (rid ? 32'd9 : 32'd11)) sum_err++;
      if (fp_rv && (fp_rid !== 1'b0 || fp_rsum !== 32'd11)) sum_err++;
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    total++; if (rr_cyc.size() != 4) begin bad++;
      $display("FAIL rr_count: got %0d grants want 4", rr_cyc.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++;
      if (rr_cyc[i] != 3 * i || rr_id[i] !== logic'(i % 2)) begin bad++;
        $display("FAIL rr_grant%0d: cycle=%0d id=%b want cycle=%0d id=%0d", i, rr_cyc[i], rr_id[i], 3 * i, i % 2); end
    end
    total++; if (fp_cyc.size() != 4) begin bad++;
      $display("FAIL fp_count: got %0d grants want 4", fp_cyc.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++;
      if (fp_cyc[i] != 3 * i || fp_id[i] !== 1'b0) begin bad++;
        $display("FAIL fp_grant%0d: cycle=%0d id=%b want cycle=%0d id=0", i, fp_cyc[i], fp_id[i], 3 * i); end
    end
    total++; if (sum_err != 0) begin bad++;
      $display("FAIL rr_results: %0d wrong responses want 0", sum_err); end
    step(); step(); step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] sum; logic id, ovf, to; int lat;
    int unstable = 0;
    issue(1'b0, 32'h100, 32'h23, 1'b0, sum, id, ovf, lat, to);
    total++; if (to || sum !== 32'h123) begin bad++;
      $display("FAIL bp_result: sum=%h want 00000123", sum); end
    v0 = 1'b1; a0 = 32'd1; b0 = 32'd1; s0 = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (rv !== 1'b1 || rsum !== 32'h123 || rid !== 1'b0 || r0_rdy !== 1'b0 || r1_rdy !== 1'b0) unstable++;
      step();
    end
    total++; if (unstable != 0) begin bad++;
      $display("FAIL bp_hold: %0d unstable cycles want 0", unstable); end
    handshake();
    total++; if (rv !== 1'b0 || r0_rdy !== 1'b1) begin bad++;
      $display("FAIL bp_release: valid=%b r0_ready=%b want 0/1", rv, r0_rdy); end
    step();
    v0 = 1'b0;
    total++; if (r0_rdy !== 1'b0) begin bad++;
      $display("FAIL bp_exec_ready: got %b want 0", r0_rdy); end
    step();
    total++; if (rv !== 1'b1 || rsum !== 32'd2) begin bad++;
      $display("FAIL bp_next_op: valid=%b sum=%h want 1/00000002", rv, rsum); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    v0 = 1'b1; a0 = 32'd9; b0 = 32'd9; s0 = 1'b0;
    #1;
    total++; if (r0_rdy !== 1'b1) begin bad++;
      $display("FAIL mid_accept: r0_ready=%b want 1", r0_rdy); end
    step();
    v0 = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin bad++;
      $display("FAIL mid_rst_ready: got %b%b want 00", r0_rdy, r1_rdy); end
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (rv !== 1'b0 || rsum !== 32'h0) spurious++;
      step();
    end
    rsp_ready = 1'b0;
    total++; if (spurious != 0) begin bad++;
      $display("FAIL mid_no_response: %0d cycles with response want 0", spurious); end
    v0 = 1'b1; v1 = 1'b1;
    #1;
    total++; if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin bad++;
      $display("FAIL mid_last_id: r0=%b r1=%b want r0=1 r1=0", r0_rdy, r1_rdy); end
    v0 = 1'b0; v1 = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-requester arbiter and sequencer that shares one 32-bit add/subtract unit between independent clients. It accepts operations over valid/ready handshakes, grants one requester at a time (round-robin or fixed priority), drives the shared unit from registered operands and returns a tagged result over a valid/ready response channel. It sits between the client pipelines and the single add/subtract datapath instance, which it instantiates internally.

## Interface

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 operation available.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  32  requester 0 operand A.
- req0_b  input  32  requester 0 operand B.
- req0_sub  input  1  requester 0 op: 0 = A+B, 1 = A−B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that issued the result.
- rsp_sum  output  32  result, modulo 2^32.
- rsp_ovf  output  1  signed overflow; present only with ADDSUB_ARB_OVF_EN.

Clock is clk; reset is rst, synchronous and active-high.

## Operation

- Datapath: sum = a + (b ^ {32{sub}}) + sub, 32-bit, carry-out discarded; subtraction is two's complement A−B.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, select grant; reqN_ready = 1 for granted requester only (combinational, IDLE && grant). On that cycle's edge: capture a, b, sub, id into operand registers; go EXEC. No valid: stay IDLE, both ready = 0.
- EXEC: operand registers drive the add/subtract unit; at edge, register sum (and overflow), rsp_id ← captured id; go RESP.
- RESP: rsp_valid = 1; rsp_sum, rsp_id, rsp_ovf held stable until rsp_valid && rsp_ready; on that edge go IDLE. Both reqN_ready = 0 in EXEC and RESP.
- Arbitration, RR_EN = 1: pointer last_id; single valid → grant it; both valid → grant !last_id. last_id updates to granted id at accept edge. Reset value last_id = 1 (requester 0 wins first tie).
- Arbitration, RR_EN = 0: requester 0 wins any tie; last_id unused.
- Requesters may drop valid without acceptance; block never latches data on a cycle with ready = 0.
- Overflow: ovf = (a[31] == bx[31]) && (sum[31] != a[31]), bx = b ^ {32{sub}}.

## Timing

- Reset values: state IDLE, req0_ready = 0, req1_ready = 0 during rst, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_ovf = 0, last_id = 1.
- Latency: accept in cycle T → rsp_valid high in cycle T+2.
- Throughput: with rsp_ready held high, one op per 3 cycles (accept T, EXEC T+1, RESP T+2, next accept T+3 earliest).
- rsp_ready low: RESP held indefinitely, outputs stable, no new accept.
- rst asserted in any state: in-flight op dropped, no response issued, all registers to reset values next edge; ready outputs 0 while rst high.
- rsp_ready high while rsp_valid low: ignored.

## Configuration

- ADDSUB_ARB_OVF_EN defined: rsp_ovf port and overflow register present, behaviour as above.
- ADDSUB_ARB_OVF_EN undefined: rsp_ovf port and overflow logic absent; all other behaviour identical.

## Test plan

- Reset: hold rst 2 cycles with both valid high → both ready 0, rsp_valid 0, rsp_sum 0; after release, req0 granted first.
- Single add: req0 a=0x0000_0005, b=0x0000_0003, sub=0 → rsp_valid at T+2, rsp_sum=0x0000_0008, rsp_id=0, ovf=0.
- Subtract/wrap: req1 a=0x0000_0000, b=0x0000_0001, sub=1 → rsp_sum=0xFFFF_FFFF, rsp_id=1, ovf=0; a=0x7FFF_FFFF, b=1, sub=0 → rsp_sum=0x8000_0000, ovf=1.
- Round-robin: both valid continuously, rsp_ready=1, RR_EN=1 → grants 0,1,0,1, rsp_id alternating; with RR_EN=0 → all grants to 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_sum stable, reqN_ready 0; rsp_ready=1 → handshake, IDLE next cycle, next accept following cycle.
- Reset mid-op: assert rst during EXEC → no response ever issued for that op, state IDLE, last_id=1.
